arb_grant_mux: RTL and testbench
================================

Name: arb_grant_mux

Overview:
- Downstream consumer of the 8-way arbiter grant.
- Drives the `req` vector from per-source valids and takes the one-hot `grant` back in the same cycle.
- Muxes the granted source's payload into a single registered output with a valid/ready handshake.
- Suppresses `req` while the output is stalled, so a round-robin arbiter's pointer only advances on real transfers.

Parameters:
N, 8, number of requesters; must match arbiter width.
W, 32, payload width per source.
IDX_W, $clog2(N) (3), width of the source-index output; derived, not overridden.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  N  per-source payload valid.
in_data  in  N*W  packed payloads; source i occupies bits [i*W +: W].
in_ready  out  N  per-source accept; at most one bit high per cycle.
req  out  N  request vector to the arbiter.
grant  in  N  one-hot grant from the arbiter, combinational from req in the same cycle.
out_valid  out  1  registered output valid.
out_data  out  W  registered payload.
out_src  out  IDX_W  index of the source that produced out_data.
out_ready  in  1  downstream accept.
err_grant  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_src=0, err_grant=0; lock state cleared.
- load_en = ~out_valid | out_ready (output register empty or draining this cycle).
- req = in_valid & {N{load_en}}; req is all-zero whenever the output is stalled.
- in_ready = grant & in_valid & {N{load_en}}.
- accept = |in_ready. On accept, next edge:
  - out_data <= selected in_data;
  - out_src <= binary index of the grant bit;
  - out_valid <= 1.
- If load_en and no accept, next edge: out_valid <= 0.
- out_valid & ~out_ready: out_data and out_src hold stable; out_valid stays 1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle with out_ready held high (back-to-back load while draining).
- err_grant sets and stays set until reset when either:
  - popcount(grant) > 1; or
  - grant & ~req is nonzero.
- On an erroring cycle, no accept happens (in_ready forced to 0).
- in_valid=0 everywhere: req=0, no transfer, output drains normally.
- Reset mid-operation discards the held beat; no in_ready is asserted during reset.

Optional Feature:
- Macro: ARB_GRANT_MUX_PKT_LOCK_EN.
- Defined: adds ports `in_last` (in, N) and `out_last` (out, 1), plus a two-state FSM.
  - ARB: normal per-beat arbitration. An accepted beat with in_last=0 → LOCKED, recording lock_src.
  - LOCKED: req = onehot(lock_src) & in_valid & load_en. The arbiter grant is still checked against req.
  - LOCKED: only lock_src may assert in_ready. An accepted beat with in_last=1 → ARB.
  - out_last registers the accepted in_last; its reset value is 0.
  - Reset in LOCKED → ARB.
- Undefined: no last ports; every beat is arbitrated independently.

Decomposition:
- Shared package `arb_pkg`:
  - constants ARB_N=8, ARB_IDX_W=3;
  - typedef `arb_vec_t` (logic [ARB_N-1:0]);
  - function `onehot2idx`;
  - function `is_onehot0` (true when the vector is zero or one-hot).
- One natural sub-module `onehot_mux`: N-way one-hot AND-OR payload mux, parameterised on N and W. It is reused for out_data and index encoding.

Test Plan:
- Single source: in_valid=8'h04, data[2]=32'hA5A5_0002, out_ready=1 → req=8'h04, grant=8'h04, in_ready=8'h04; next cycle out_valid=1, out_data=32'hA5A5_0002, out_src=2.
- Backpressure: out_valid=1, out_ready=0, in_valid=8'hFF → req=8'h00, in_ready=8'h00 for every stalled cycle. out_data stays stable; the round-robin arbiter pointer does not move.
- Streaming: in_valid=8'hFF held, out_ready=1 for 16 cycles, round-robin arbiter attached → out_src sequence 0,1,…,7,0,…,7 with no bubble after the first cycle.
- Bad grant: force grant=8'h03 with req=8'h03 → in_ready=0, err_grant=1 next cycle and still 1 after 10 clean cycles. rst=1 for one edge → err_grant=0, out_valid=0.
- Lock (macro defined): source 1 sends 3 beats with last=0,0,1 while source 5 is continuously valid → out_src=1,1,1, then 5.
- Lock reset: rst asserted mid-packet → FSM returns to ARB, out_valid=0, and the next transfer is arbitrated freshly.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, types and helpers for the arbiter grant path.
package arb_pkg;

    localparam int unsigned ARB_N     = 8;
    localparam int unsigned ARB_IDX_W = 3;

    typedef logic [ARB_N-1:0]     arb_vec_t;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    // Packet-lock FSM states (used only when packet locking is built in)
    typedef enum logic {
        StArb    = 1'b0,
        StLocked = 1'b1
    } lock_state_e;

    // Binary index of a one-hot vector; zero for an all-zero vector.
    function automatic arb_idx_t onehot2idx(arb_vec_t vec);
        arb_idx_t idx;
        idx = '0;
        for (int i = 0; i < ARB_N; i++) begin
            if (vec[i]) begin
                idx = idx | arb_idx_t'(i);
            end
        end
        return idx;
    endfunction

    // True when the vector has at most one bit set.
    function automatic logic is_onehot0(arb_vec_t vec);
        return (vec & (vec - arb_vec_t'(1))) == '0;
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// N-way AND-OR multiplexer driven by a one-hot (or all-zero) select.
module onehot_mux #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 32
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o
);

    // OR together every lane whose select bit is set
    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            data_o = data_o | ({W{sel_i[i]}} & data_i[i*W +: W]);
        end
    end

endmodule

// File: rtl/arb_grant_mux.sv
// Consumer of an 8-way arbiter grant: builds req from source valids, muxes the
// granted payload into a registered valid/ready output stage and flags bad grants.
// Optional packet locking is compiled in with `define ARB_GRANT_MUX_PKT_LOCK_EN,
// which adds in_last/out_last and holds the grant on one source until its last beat.
module arb_grant_mux
    import arb_pkg::*;
#(
    parameter  int unsigned N     = ARB_N,
    parameter  int unsigned W     = 32,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
    output logic [N-1:0]     in_ready,
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
    input  logic [N-1:0]     in_last,
    output logic             out_last,
`endif
    output logic [N-1:0]     req,
    input  logic [N-1:0]     grant,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_src,
    input  logic             out_ready,
    output logic             err_grant
);

    // The package helpers are sized for the arbiter width
    if (N != ARB_N) begin : g_bad_width
        $error("arb_grant_mux: N must equal ARB_N");
    end

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;
    logic             err_q, err_d;

    logic             load_en;
    logic [N-1:0]     req_mask;
    logic             err_now;
    logic             accept;
    logic [W-1:0]     sel_data;
    logic [IDX_W-1:0] sel_idx;
    logic [N*IDX_W-1:0] idx_table;

    // Output register is empty or draining this cycle
    assign load_en = ~out_valid_q | out_ready;

`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] lock_src_q, lock_src_d;
    logic             out_last_q, out_last_d;
    logic             sel_last;

    // While locked only the owning source may request
    assign req_mask = (state_q == StLocked) ? (N'(1) << lock_src_q) : '1;
    assign sel_last = |(in_ready & in_last);
    assign out_last = out_last_q;

    // Lock FSM next state: enter on a non-last beat, leave on the last beat
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        out_last_d = out_last_q;
        if (accept) begin
            out_last_d = sel_last;
        end
        unique case (state_q)
            StArb: begin
                if (accept && !sel_last) begin
                    state_d    = StLocked;
                    lock_src_d = onehot2idx(in_ready);
                end
            end
            StLocked: begin
                if (accept && sel_last) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    // Lock FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StArb;
            lock_src_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            out_last_q <= out_last_d;
        end
    end
`else
    assign req_mask = '1;
`endif

    // Requests are withheld while stalled so the arbiter pointer only moves on transfers
    assign req = in_valid & req_mask & {N{load_en}};

    // Multiple grants or a grant without a request both count as protocol errors
    assign err_now  = ~is_onehot0(grant) | (|(grant & ~req));
    assign in_ready = (err_now | rst) ? '0 : (grant & req);
    assign accept   = |in_ready;

    // Constant table of lane indices so the same mux yields the source number
    always_comb begin
        idx_table = '0;
        for (int i = 0; i < N; i++) begin
            idx_table[i*IDX_W +: IDX_W] = IDX_W'(i);
        end
    end

    onehot_mux #(
        .N (N),
        .W (W)
    ) u_data_mux (
        .sel_i  (in_ready),
        .data_i (in_data),
        .data_o (sel_data)
    );

    onehot_mux #(
        .N (N),
        .W (IDX_W)
    ) u_idx_mux (
        .sel_i  (in_ready),
        .data_i (idx_table),
        .data_o (sel_idx)
    );

    // Output stage next state: load on accept, empty when draining without accept
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        err_d       = err_q | err_now;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = sel_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and sticky error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign err_grant = err_q;

endmodule

// File: tb/tb_arb_grant_mux.sv
// Randomized and directed bench for arb_grant_mux with a behavioural reference
// model and a behavioural round-robin arbiter closing the req/grant loop.
module tb_arb_grant_mux;

    localparam int unsigned N = 8;
    localparam int unsigned W = 32;
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [2:0]     out_src;
    logic           out_ready;
    logic           err_grant;
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
    logic [N-1:0]   in_last;
    logic           out_last;
`endif

    always #5 clk = ~clk;

    arb_grant_mux #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .req       (req),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .err_grant (err_grant)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    bit           m_err;
    bit           m_last;
    bit           m_locked;
    int           m_lsrc;
    int           arb_ptr;
    logic [W-1:0] src_data [N];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int low_idx(logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    // Round-robin pick starting at ptr
    function automatic logic [N-1:0] rr_pick(logic [N-1:0] r, int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (r[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    task automatic drive_data();
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = src_data[i];
        end
    endtask

    // One clock: drive, close the arbiter loop, check combinational and registered outputs
    task automatic step(input logic [N-1:0] iv, input bit ordy, input logic [N-1:0] lst,
                        input bit force_g, input logic [N-1:0] fg);
        logic [N-1:0] exp_req, exp_rdy, mask;
        bit           load, bad;
        int           idx;
        @(negedge clk);
        in_valid  = iv;
        out_ready = ordy;
        drive_data();
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        in_last = lst;
`endif
        #1;
        grant = force_g ? fg : rr_pick(req, arb_ptr);
        #1;
        load    = !m_valid || ordy;
        mask    = (LockEn && m_locked) ? (N'(1) << m_lsrc) : '1;
        exp_req = load ? (iv & mask) : '0;
        bad     = ($countones(grant) > 1) || ((grant & ~exp_req) != '0);
        exp_rdy = bad ? '0 : (grant & exp_req);
        check_eq("req", 64'(req), 64'(exp_req));
        check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (!force_g && grant != '0) arb_ptr = (low_idx(grant) + 1) % N;
        m_err = m_err || bad;
        if (exp_rdy != '0) begin
            idx     = low_idx(exp_rdy);
            m_valid = 1'b1;
            m_data  = src_data[idx];
            m_src   = idx;
            m_last  = lst[idx];
            if (LockEn && !m_locked && !lst[idx]) begin
                m_locked = 1'b1;
                m_lsrc   = idx;
            end else if (m_locked && lst[idx]) begin
                m_locked = 1'b0;
            end
        end else if (load) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            check_eq("out_data", 64'(out_data), 64'(m_data));
            check_eq("out_src", 64'(out_src), 64'(m_src));
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
            check_eq("out_last", 64'(out_last), 64'(m_last));
`endif
        end
        check_eq("err_grant", 64'(err_grant), 64'(m_err));
    endtask

    // One reset edge with live traffic presented; the arbiter pointer is left alone
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b1;
        drive_data();
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        in_last = '0;
`endif
        #1;
        grant = rr_pick(req, arb_ptr);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        grant    = '0;
        in_valid = '0;
        m_valid  = 1'b0;
        m_data   = '0;
        m_src    = 0;
        m_err    = 1'b0;
        m_last   = 1'b0;
        m_locked = 1'b0;
        m_lsrc   = 0;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_data", 64'(out_data), 64'(0));
        check_eq("rst_out_src", 64'(out_src), 64'(0));
        check_eq("rst_err_grant", 64'(err_grant), 64'(0));
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        check_eq("rst_out_last", 64'(out_last), 64'(0));
`endif
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) src_data[i] = $urandom;
    endtask

    initial begin
        logic [W-1:0] held;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        grant     = '0;
        out_ready = 1'b0;
`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        in_last = '0;
`endif
        arb_ptr = 0;
        rand_data();
        do_reset();

        // Single source
        arb_ptr     = 0;
        src_data[2] = 32'hA5A5_0002;
        step(8'h04, 1'b1, '1, 1'b0, '0);
        check_eq("single_data", 64'(out_data), 64'h0000_0000_A5A5_0002);
        check_eq("single_src", 64'(out_src), 64'd2);

        // Backpressure: stalled output, all sources valid
        held = out_data;
        for (int i = 0; i < 4; i++) begin
            rand_data();
            step(8'hFF, 1'b0, '1, 1'b0, '0);
            check_eq("bp_hold_data", 64'(out_data), 64'(held));
        end
        step(8'hFF, 1'b1, '1, 1'b0, '0);
        check_eq("bp_release_src", 64'(out_src), 64'd3);

        // Streaming with round-robin arbiter
        do_reset();
        arb_ptr = 0;
        for (int i = 0; i < 16; i++) begin
            rand_data();
            step(8'hFF, 1'b1, '1, 1'b0, '0);
            check_eq("stream_valid", 64'(out_valid), 64'd1);
            check_eq("stream_src", 64'(out_src), 64'(i % 8));
        end

        // Bad grant: two bits set
        do_reset();
        step(8'h03, 1'b1, '1, 1'b1, 8'h03);
        check_eq("bad_err_set", 64'(err_grant), 64'd1);
        for (int i = 0; i < 10; i++) step(8'h00, 1'b1, '1, 1'b0, '0);
        check_eq("bad_err_sticky", 64'(err_grant), 64'd1);
        // Bad grant: grant without request
        do_reset();
        step(8'h01, 1'b1, '1, 1'b1, 8'h10);
        check_eq("unreq_err_set", 64'(err_grant), 64'd1);
        do_reset();

`ifdef ARB_GRANT_MUX_PKT_LOCK_EN
        // Packet lock: source 1 sends three beats while source 5 waits
        arb_ptr = 0;
        step(8'h22, 1'b1, 8'h00, 1'b0, '0);
        check_eq("lock_src0", 64'(out_src), 64'd1);
        step(8'h22, 1'b1, 8'h00, 1'b0, '0);
        check_eq("lock_src1", 64'(out_src), 64'd1);
        step(8'h22, 1'b1, 8'h02, 1'b0, '0);
        check_eq("lock_src2", 64'(out_src), 64'd1);
        check_eq("lock_last", 64'(out_last), 64'd1);
        step(8'h20, 1'b1, 8'hFF, 1'b0, '0);
        check_eq("lock_src3", 64'(out_src), 64'd5);
        // Reset mid-packet returns to fresh arbitration
        arb_ptr = 0;
        step(8'h22, 1'b1, 8'h00, 1'b0, '0);
        do_reset();
        step(8'h22, 1'b1, 8'hFF, 1'b0, '0);
        check_eq("lock_rst_src", 64'(out_src), 64'd5);
`endif

        // Randomized traffic with occasional bad grants and resets
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] iv, fg;
            bit           ordy, fbad;
            rand_data();
            iv   = N'($urandom) & N'($urandom | $urandom);
            ordy = ($urandom_range(0, 3) != 0);
            fbad = ($urandom_range(0, 49) == 0);
            fg   = N'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(iv, ordy, N'($urandom), fbad, fg);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
